// File: rtl/giga_loader_if.sv
// Byte-stream input and instruction-memory write port of the program loader.
// The slave modport is the loader's view; the master modport is the view of
// whatever feeds bytes in and watches the memory writes.
interface giga_loader_if #(
  parameter int ADDR_W = 9
);
  logic              in_valid;
  logic [7:0]        in_data;
  logic              in_ready;
  logic              im_we;
  logic [ADDR_W-1:0] im_addr;
  logic [31:0]       im_d;

  modport master (
    output in_valid, in_data,
    input  in_ready, im_we, im_addr, im_d
  );

  modport slave (
    input  in_valid, in_data,
    output in_ready, im_we, im_addr, im_d
  );
endinterface

// File: rtl/giga_loader.sv
// Program loader: reads a 16-bit big-endian word count followed by that many
// big-endian 32-bit words from a byte stream, writes them to instruction
// memory at consecutive addresses from 0, and keeps the core held in reset
// until a load completes successfully.
module giga_loader #(
  parameter int ADDR_W    = 9,
  parameter int MAX_WORDS = 512
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  giga_loader_if.slave      bus,
  output logic              core_hold,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [ADDR_W:0]   words_loaded
);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] HDR_HI  = 3'd1;
  localparam logic [2:0] HDR_LO  = 3'd2;
  localparam logic [2:0] COLLECT = 3'd3;
  localparam logic [2:0] WRITE   = 3'd4;
  localparam logic [2:0] DONE    = 3'd5;
  localparam logic [2:0] ERROR   = 3'd6;

  localparam logic [16:0] MAX_N = 17'(MAX_WORDS);

  logic [2:0]  state;
  logic [7:0]  n_hi;
  logic [15:0] n_words;
  logic [23:0] partial;
  logic [1:0]  byte_cnt;

  logic        accept;
  logic        start_ok;
  logic [15:0] header;
  logic [15:0] next_count;

  assign accept     = bus.in_valid && bus.in_ready;
  assign start_ok   = start && (state == IDLE || state == DONE || state == ERROR);
  assign header     = {n_hi, bus.in_data};
  assign next_count = 16'(words_loaded) + 16'd1;

  // Status and handshake outputs decode straight from the state register so
  // that an asynchronous reset reaches them in the same cycle.
  assign bus.in_ready = (state == HDR_HI) || (state == HDR_LO) || (state == COLLECT);
  assign bus.im_we    = (state == WRITE);
  assign busy         = (state == HDR_HI) || (state == HDR_LO) ||
                        (state == COLLECT) || (state == WRITE);
  assign done         = (state == DONE);
  assign error        = (state == ERROR);
  assign core_hold    = (state != DONE);

  // Load sequencer: header capture, byte assembly, one-cycle memory write.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      n_hi         <= '0;
      n_words      <= '0;
      partial      <= '0;
      byte_cnt     <= '0;
      words_loaded <= '0;
      bus.im_addr  <= '0;
      bus.im_d     <= '0;
    end else if (start_ok) begin
      state        <= HDR_HI;
      words_loaded <= '0;
      byte_cnt     <= '0;
    end else begin
      case (state)
        HDR_HI: begin
          if (accept) begin
            n_hi  <= bus.in_data;
            state <= HDR_LO;
          end
        end
        HDR_LO: begin
          if (accept) begin
            n_words  <= header;
            byte_cnt <= '0;
            if (header == 16'd0 || {1'b0, header} > MAX_N) begin
              state <= ERROR;
            end else begin
              state <= COLLECT;
            end
          end
        end
        COLLECT: begin
          if (accept) begin
            partial  <= {partial[15:0], bus.in_data};
            byte_cnt <= byte_cnt + 2'd1;
            if (byte_cnt == 2'd3) begin
              bus.im_d    <= {partial, bus.in_data};
              bus.im_addr <= words_loaded[ADDR_W-1:0];
              state       <= WRITE;
            end
          end
        end
        WRITE: begin
          words_loaded <= words_loaded + 1'b1;
          if (next_count == n_words) begin
            state <= DONE;
          end else begin
            state <= COLLECT;
          end
        end
        default: begin
          state <= state;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_giga_loader.sv
// Testbench for giga_loader: table of load scenarios with random payloads,
// checked against a word-list model, plus reset-mid-load sequences.
module tb_giga_loader;

  localparam int ADDR_W    = 9;
  localparam int MAX_WORDS = 512;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            start = 1'b0;
  logic            core_hold;
  logic            busy;
  logic            done;
  logic            error;
  logic [ADDR_W:0] words_loaded;

  giga_loader_if #(.ADDR_W(ADDR_W)) bus ();

  giga_loader #(.ADDR_W(ADDR_W), .MAX_WORDS(MAX_WORDS)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .bus          (bus),
    .core_hold    (core_hold),
    .busy         (busy),
    .done         (done),
    .error        (error),
    .words_loaded (words_loaded)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int last_accept = 0;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [31:0]       data;
    int                cycle;
  } wr_t;

  typedef struct {
    logic [15:0] n;
    int          gap;
    int          start_at;
    bit          fixed;
  } load_vec_t;

  wr_t seen[$];
  int  accept_cycles[$];
  wr_t mon_w;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Record every memory write strobe seen mid-cycle.
  always @(negedge clk) begin
    if (bus.im_we === 1'b1) begin
      mon_w.addr  = bus.im_addr;
      mon_w.data  = bus.im_d;
      mon_w.cycle = cyc;
      seen.push_back(mon_w);
      checkOutput("im_addr in range", 32'(bus.im_addr < MAX_WORDS), 32'd1);
    end
  end

  // Offer one byte after 'gap' idle cycles; returns at posedge+1 after acceptance.
  task automatic applyStimulus(input logic [7:0] b, input int gap, input bit with_start);
    int waited;
    bit got;
    repeat (gap) begin
      @(posedge clk);
      #1;
    end
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    if (with_start) start = 1'b1;
    got = 1'b0;
    waited = 0;
    while (!got && waited < 50) begin
      @(negedge clk);
      if (bus.in_ready === 1'b1) begin
        got = 1'b1;
        last_accept = cyc;
      end
      @(posedge clk);
      #1;
      start = 1'b0;
      waited++;
    end
    bus.in_valid = 1'b0;
    if (!got) checkOutput("byte accept timeout", 32'd0, 32'd1);
  endtask

  task automatic pulseStart();
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // One complete load: model builds the expected word list, then compares.
  task automatic runLoad(input load_vec_t v);
    logic [31:0] words[$];
    logic [31:0] w;
    bit          legal;
    int          n;
    int          waited;
    n = int'(v.n);
    legal = (n != 0) && (n <= MAX_WORDS);
    words.delete();
    if (legal) begin
      for (int i = 0; i < n; i++) begin
        if (v.fixed) words.push_back(i == 0 ? 32'h24080005 : 32'h0000000C);
        else         words.push_back($urandom);
      end
    end
    seen.delete();
    accept_cycles.delete();

    pulseStart();
    checkOutput("busy after start", 32'(busy), 32'd1);
    checkOutput("done cleared by start", 32'(done), 32'd0);
    checkOutput("error cleared by start", 32'(error), 32'd0);
    checkOutput("words_loaded cleared", 32'(words_loaded), 32'd0);

    applyStimulus(v.n[15:8], v.gap, 1'b0);
    applyStimulus(v.n[7:0], v.gap, 1'b0);
    for (int i = 0; i < words.size(); i++) begin
      w = words[i];
      for (int k = 0; k < 4; k++) begin
        applyStimulus(w[31-8*k -: 8], v.gap, (i*4 + k) == v.start_at);
        if (k == 3) accept_cycles.push_back(last_accept);
      end
    end

    waited = 0;
    while (busy === 1'b1 && waited < 20) begin
      @(posedge clk);
      #1;
      waited++;
    end
    checkOutput("busy drops at end", 32'(busy), 32'd0);

    if (!legal) begin
      bus.in_valid = 1'b1;
      bus.in_data  = 8'hA5;
      repeat (3) begin
        @(negedge clk);
        checkOutput("in_ready low in error", 32'(bus.in_ready), 32'd0);
      end
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
    end

    checkOutput("done", 32'(done), 32'(legal));
    checkOutput("error", 32'(error), 32'(!legal));
    checkOutput("core_hold", 32'(core_hold), 32'(!legal));
    checkOutput("in_ready idle", 32'(bus.in_ready), 32'd0);
    checkOutput("words_loaded", 32'(words_loaded), legal ? 32'(n) : 32'd0);
    checkOutput("write count", 32'(seen.size()), legal ? 32'(n) : 32'd0);
    for (int i = 0; i < seen.size() && i < words.size(); i++) begin
      checkOutput("write addr", 32'(seen[i].addr), 32'(i));
      checkOutput("write data", seen[i].data, words[i]);
      checkOutput("write latency", 32'(seen[i].cycle), 32'(accept_cycles[i] + 1));
    end
    if (legal) begin
      checkOutput("im_addr holds", 32'(bus.im_addr), 32'(n - 1));
      checkOutput("im_d holds", bus.im_d, words[n-1]);
    end
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, " im_we"}, 32'(bus.im_we), 32'd0);
    checkOutput({tag, " im_addr"}, 32'(bus.im_addr), 32'd0);
    checkOutput({tag, " im_d"}, bus.im_d, 32'd0);
    checkOutput({tag, " in_ready"}, 32'(bus.in_ready), 32'd0);
    checkOutput({tag, " busy"}, 32'(busy), 32'd0);
    checkOutput({tag, " done"}, 32'(done), 32'd0);
    checkOutput({tag, " error"}, 32'(error), 32'd0);
    checkOutput({tag, " words_loaded"}, 32'(words_loaded), 32'd0);
    checkOutput({tag, " core_hold"}, 32'(core_hold), 32'd1);
  endtask

  initial begin
    #2ms;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  load_vec_t vecs[10];
  load_vec_t rv;
  logic [31:0] rst_word;

  initial begin
    vecs[0] = '{n: 16'd2,     gap: 0, start_at: -1, fixed: 1'b1};
    vecs[1] = '{n: 16'd2,     gap: 3, start_at: -1, fixed: 1'b1};
    vecs[2] = '{n: 16'd0,     gap: 0, start_at: -1, fixed: 1'b0};
    vecs[3] = '{n: 16'h0201,  gap: 0, start_at: -1, fixed: 1'b0};
    vecs[4] = '{n: 16'd2,     gap: 0, start_at: 5,  fixed: 1'b1};
    vecs[5] = '{n: 16'd1,     gap: 0, start_at: -1, fixed: 1'b0};
    vecs[6] = '{n: 16'd5,     gap: 1, start_at: 2,  fixed: 1'b0};
    vecs[7] = '{n: 16'd513,   gap: 0, start_at: -1, fixed: 1'b0};
    vecs[8] = '{n: 16'd3,     gap: 2, start_at: 9,  fixed: 1'b0};
    vecs[9] = '{n: 16'd512,   gap: 0, start_at: -1, fixed: 1'b0};

    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    #1 rst = 1'b0;
    #2;
    checkResetValues("power-on");
    @(posedge clk);
    #1 rst = 1'b1;

    for (int i = 0; i < 10; i++) runLoad(vecs[i]);

    for (int i = 0; i < 4; i++) begin
      rv.n        = 16'($urandom_range(1, 8));
      rv.gap      = $urandom_range(0, 2);
      rv.start_at = $urandom_range(0, 4);
      rv.fixed    = 1'b0;
      runLoad(rv);
    end

    // Reset after six payload bytes: only the first word may be written.
    seen.delete();
    pulseStart();
    applyStimulus(8'h00, 0, 1'b0);
    applyStimulus(8'h02, 0, 1'b0);
    rst_word = $urandom;
    for (int k = 0; k < 4; k++) applyStimulus(rst_word[31-8*k -: 8], 0, 1'b0);
    applyStimulus(8'h11, 0, 1'b0);
    applyStimulus(8'h22, 0, 1'b0);
    #2 rst = 1'b0;
    #1;
    checkResetValues("mid-load reset");
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    checkOutput("writes before reset", 32'(seen.size()), 32'd1);
    if (seen.size() > 0) begin
      checkOutput("reset-run addr", 32'(seen[0].addr), 32'd0);
      checkOutput("reset-run data", seen[0].data, rst_word);
    end

    // Without a fresh start the loader must not take bytes.
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h01;
    repeat (4) begin
      @(negedge clk);
      checkOutput("no load without start", 32'(bus.in_ready), 32'd0);
    end
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    checkOutput("no writes after reset", 32'(seen.size()), 32'd1);

    runLoad(vecs[0]);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
